// File: rtl/cwt_sched_if.sv
// Bundled handshake signals between the CWT sequencer and its environment
// (frame control, sub-block start/done pairs, BRAM read-out stream).
interface cwt_sched_if #(
    parameter int N  = 1024,
    parameter int J1 = 4
);
    localparam int SW = (J1 > 1) ? $clog2(J1) : 1;
    localparam int AW = $clog2(N * J1);

    logic          start_i;
    logic          dl_busy_i;
    logic          busy_o;
    logic          cwt_done_o;
    logic [2:0]    state_o;
    logic          fft_start_o;
    logic          fft_done_i;
    logic          mul_start_o;
    logic [SW-1:0] mul_scale_o;
    logic          mul_done_i;
    logic          ifft_start_o;
    logic          ifft_done_i;
    logic          store_start_o;
    logic [AW-1:0] store_base_o;
    logic          store_done_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic          valid_o;
    logic          last_o;

    modport master (
        input  start_i, dl_busy_i, fft_done_i, mul_done_i, ifft_done_i, store_done_i,
        output busy_o, cwt_done_o, state_o, fft_start_o, mul_start_o, mul_scale_o,
               ifft_start_o, store_start_o, store_base_o, rd_en_o, rd_addr_o,
               valid_o, last_o
    );

    modport slave (
        output start_i, dl_busy_i, fft_done_i, mul_done_i, ifft_done_i, store_done_i,
        input  busy_o, cwt_done_o, state_o, fft_start_o, mul_start_o, mul_scale_o,
               ifft_start_o, store_start_o, store_base_o, rd_en_o, rd_addr_o,
               valid_o, last_o
    );
endinterface

// File: rtl/cwt_sched.sv
// CWT frame sequencer: one FFT, then MUL/IFFT/STORE per scale, then a
// backpressured read-out of all N*J1 stored results.
module cwt_sched #(
    parameter int N  = 1024,
    parameter int J1 = 4
) (
    input  logic         clk,
    input  logic         rst,
    cwt_sched_if.master  bus
);
    localparam int SW    = (J1 > 1) ? $clog2(J1) : 1;
    localparam int AW    = $clog2(N * J1);
    localparam int LOG2N = $clog2(N);
    localparam logic [SW-1:0] J_LAST = SW'(J1 - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N * J1 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FFT   = 3'd1,
        S_MUL   = 3'd2,
        S_IFFT  = 3'd3,
        S_STORE = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] j_q, j_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] store_base_q, store_base_d;
    logic          fft_start_q, fft_start_d;
    logic          mul_start_q, mul_start_d;
    logic          ifft_start_q, ifft_start_d;
    logic          store_start_q, store_start_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          rd_en;

    // Handshakes: each *_start_o is high only in the first cycle of its wait
    // state; the matching *_done_i advances the FSM only in that wait state
    // and never in the start cycle. The read side issues whenever dl_busy_i
    // is low, and valid_o follows rd_en_o by exactly one cycle.
    always_comb begin
        state_d       = state_q;
        j_d           = j_q;
        rd_addr_d     = rd_addr_q;
        store_base_d  = store_base_q;
        fft_start_d   = 1'b0;
        mul_start_d   = 1'b0;
        ifft_start_d  = 1'b0;
        store_start_d = 1'b0;
        valid_d       = 1'b0;
        last_d        = 1'b0;
        rd_en         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d     = S_FFT;
                    fft_start_d = 1'b1;
                end
            end
            S_FFT: begin
                if (bus.fft_done_i && !fft_start_q) begin
                    state_d     = S_MUL;
                    mul_start_d = 1'b1;
                end
            end
            S_MUL: begin
                if (bus.mul_done_i && !mul_start_q) begin
                    state_d      = S_IFFT;
                    ifft_start_d = 1'b1;
                end
            end
            S_IFFT: begin
                if (bus.ifft_done_i && !ifft_start_q) begin
                    state_d       = S_STORE;
                    store_start_d = 1'b1;
                    store_base_d  = AW'(j_q) << LOG2N;
                end
            end
            S_STORE: begin
                if (bus.store_done_i && !store_start_q) begin
                    if (j_q == J_LAST) begin
                        state_d   = S_READ;
                        rd_addr_d = '0;
                    end else begin
                        state_d     = S_MUL;
                        j_d         = j_q + SW'(1);
                        mul_start_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                rd_en = !bus.dl_busy_i;
                if (rd_en) begin
                    valid_d = 1'b1;
                    if (rd_addr_q == A_LAST) begin
                        last_d    = 1'b1;
                        rd_addr_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                j_d       = '0;
                rd_addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            j_q           <= '0;
            rd_addr_q     <= '0;
            store_base_q  <= '0;
            fft_start_q   <= 1'b0;
            mul_start_q   <= 1'b0;
            ifft_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            j_q           <= j_d;
            rd_addr_q     <= rd_addr_d;
            store_base_q  <= store_base_d;
            fft_start_q   <= fft_start_d;
            mul_start_q   <= mul_start_d;
            ifft_start_q  <= ifft_start_d;
            store_start_q <= store_start_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
        end
    end

    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.cwt_done_o    = (state_q == S_DONE);
    assign bus.state_o       = state_q;
    assign bus.fft_start_o   = fft_start_q;
    assign bus.mul_start_o   = mul_start_q;
    assign bus.mul_scale_o   = j_q;
    assign bus.ifft_start_o  = ifft_start_q;
    assign bus.store_start_o = store_start_q;
    assign bus.store_base_o  = store_base_q;
    assign bus.rd_en_o       = rd_en;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.valid_o       = valid_q;
    assign bus.last_o        = last_q;
endmodule

// File: tb/tb_cwt_sched.sv
// Bench for cwt_sched: randomized done latencies and stalls on an N=16/J1=4
// instance, plus a short directed frame on an N=8/J1=1 instance.
module tb_cwt_sched;
    localparam int N   = 16;
    localparam int J1  = 4;
    localparam int SW  = 2;
    localparam int AW  = 6;
    localparam int TOT = N * J1;
    localparam int NB  = 8;
    localparam int J1B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cwt_sched_if #(.N(N),  .J1(J1))  a ();
    cwt_sched_if #(.N(NB), .J1(J1B)) b ();

    cwt_sched #(.N(N),  .J1(J1))  dut_a (.clk(clk), .rst(rst), .bus(a.master));
    cwt_sched #(.N(NB), .J1(J1B)) dut_b (.clk(clk), .rst(rst), .bus(b.master));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- done responders ----------------
    logic [3:0] ra = '0, xa = '0, rb = '0;
    logic [3:0] st_a, st_b;
    int     cnt_a[4], cnt_b[4];
    int     lat_lo = 5, lat_hi = 5, stall_mode = 0;
    bit     early = 1'b0;
    longint lat_sum = 0;

    assign a.fft_done_i   = ra[0] | xa[0];
    assign a.mul_done_i   = ra[1] | xa[1];
    assign a.ifft_done_i  = ra[2] | xa[2];
    assign a.store_done_i = ra[3] | xa[3];
    assign b.fft_done_i   = rb[0];
    assign b.mul_done_i   = rb[1];
    assign b.ifft_done_i  = rb[2];
    assign b.store_done_i = rb[3];
    assign b.dl_busy_i    = 1'b0;

    always @(posedge clk) begin
        #1;
        st_a = {a.store_start_o, a.ifft_start_o, a.mul_start_o, a.fft_start_o};
        st_b = {b.store_start_o, b.ifft_start_o, b.mul_start_o, b.fft_start_o};
        for (int i = 0; i < 4; i++) begin
            ra[i] = 1'b0;
            rb[i] = 1'b0;
            if (rst) begin
                cnt_a[i] = 0;
                cnt_b[i] = 0;
            end else begin
                if (cnt_a[i] > 0) begin
                    cnt_a[i]--;
                    if (cnt_a[i] == 0) ra[i] = 1'b1;
                end
                if (st_a[i]) begin
                    cnt_a[i] = int'($urandom_range(lat_hi, lat_lo));
                    lat_sum += cnt_a[i];
                    if (early) ra[i] = 1'b1;
                end
                if (cnt_b[i] > 0) begin
                    cnt_b[i]--;
                    if (cnt_b[i] == 0) rb[i] = 1'b1;
                end
                if (st_b[i]) cnt_b[i] = 2;
            end
        end
    end

    // ---------------- downstream stall driver ----------------
    int stall_left = 0;
    int stall_addr = -1;
    always @(posedge clk) begin
        #1;
        if (a.state_o != 3'd5) stall_addr = -1;
        if (stall_left > 0) begin
            a.dl_busy_i = 1'b1;
            stall_left--;
        end else if (stall_mode == 1 && a.state_o == 3'd5 &&
                     (int'(a.rd_addr_o) == 10 || int'(a.rd_addr_o) == 63) &&
                     int'(a.rd_addr_o) != stall_addr) begin
            stall_addr  = int'(a.rd_addr_o);
            stall_left  = 2;
            a.dl_busy_i = 1'b1;
        end else if (stall_mode == 2) begin
            a.dl_busy_i = ($urandom_range(3, 0) == 0);
        end else begin
            a.dl_busy_i = 1'b0;
        end
    end

    // ---------------- monitors ----------------
    int n_fft = 0, n_ifft = 0, n_valid = 0, n_last = 0, n_done = 0, n_dwl = 0;
    int n_bad_rd = 0, n_verr = 0, n_lerr = 0, n_lpos = 0, n_busy_after = 0;
    int n_busy = 0, n_stall = 0, cyc = 0, last_done_cyc = 0, last_gap = 0, v_in_frame = 0;
    logic [SW-1:0] mul_log[$];
    logic [AW-1:0] base_log[$];
    logic [AW-1:0] addr_log[$];
    logic          prev_rd_en = 1'b0, prev_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_rd_en = 1'b0;
            prev_done  = 1'b0;
            v_in_frame = 0;
        end else begin
            if (a.fft_start_o) begin
                n_fft++;
                last_gap = cyc - last_done_cyc;
            end
            if (a.mul_start_o)   mul_log.push_back(a.mul_scale_o);
            if (a.ifft_start_o)  n_ifft++;
            if (a.store_start_o) base_log.push_back(a.store_base_o);
            if (a.rd_en_o)       addr_log.push_back(a.rd_addr_o);
            if (a.rd_en_o && a.dl_busy_i) n_bad_rd++;
            if (a.state_o == 3'd5 && a.dl_busy_i) n_stall++;
            if (a.valid_o !== prev_rd_en) n_verr++;
            if (a.last_o !== (prev_rd_en && prev_addr == AW'(TOT - 1))) n_lerr++;
            if (a.valid_o) begin
                n_valid++;
                v_in_frame++;
            end
            if (a.last_o) begin
                n_last++;
                if (v_in_frame != TOT) n_lpos++;
            end
            if (prev_done && a.busy_o) n_busy_after++;
            if (a.busy_o) n_busy++;
            if (a.cwt_done_o) begin
                n_done++;
                last_done_cyc = cyc;
                v_in_frame    = 0;
                if (a.last_o) n_dwl++;
            end
            prev_rd_en = a.rd_en_o;
            prev_addr  = a.rd_addr_o;
            prev_done  = a.cwt_done_o;
        end
    end

    int nb_fft = 0, nb_mul = 0, nb_scale_err = 0, nb_store = 0, nb_base_err = 0;
    int nb_rd = 0, nb_addr_err = 0, nb_exp_addr = 0, nb_valid = 0, nb_last = 0;
    int nb_done = 0, nb_dwl = 0, nb_busy = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b.fft_start_o) nb_fft++;
            if (b.mul_start_o) nb_mul++;
            if (b.mul_scale_o != 1'b0) nb_scale_err++;
            if (b.store_start_o) begin
                nb_store++;
                if (b.store_base_o != '0) nb_base_err++;
            end
            if (b.rd_en_o) begin
                nb_rd++;
                if (int'(b.rd_addr_o) != nb_exp_addr) nb_addr_err++;
                nb_exp_addr++;
            end
            if (b.valid_o) nb_valid++;
            if (b.last_o)  nb_last++;
            if (b.busy_o)  nb_busy++;
            if (b.cwt_done_o) begin
                nb_done++;
                nb_exp_addr = 0;
                if (b.last_o) nb_dwl++;
            end
        end
    end

    // ---------------- frame-level reference model ----------------
    int s_mul, s_base, s_addr, s_fft, s_ifft, s_valid, s_last, s_done, s_dwl;
    int s_bad, s_verr, s_lerr, s_lpos, s_after, s_busy, s_stall;
    longint s_lat;

    task automatic snapshot_a();
        s_mul   = mul_log.size();
        s_base  = base_log.size();
        s_addr  = addr_log.size();
        s_fft   = n_fft;    s_ifft  = n_ifft;   s_valid = n_valid;
        s_last  = n_last;   s_done  = n_done;   s_dwl   = n_dwl;
        s_bad   = n_bad_rd; s_verr  = n_verr;   s_lerr  = n_lerr;
        s_lpos  = n_lpos;   s_after = n_busy_after;
        s_busy  = n_busy;   s_stall = n_stall;  s_lat   = lat_sum;
    endtask

    task automatic wait_done_a(input int target);
        for (int k = 0; k < 4000 && n_done < target; k++) begin
            @(negedge clk); #1;
        end
        chk("frame_done_reached", n_done, target);
    endtask

    task automatic wait_state_a(input int st, input int sc);
        bit hit = 1'b0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge clk); #1;
            if (int'(a.state_o) == st && int'(a.mul_scale_o) == sc) hit = 1'b1;
        end
        chk("state_reached", hit, 1);
    endtask

    task automatic run_frame_a();
        snapshot_a();
        @(posedge clk); #1 a.start_i = 1'b1;
        @(posedge clk); #1 a.start_i = 1'b0;
        wait_done_a(s_done + 1);
    endtask

    task automatic check_frame_a(input int frames);
        int   exp_q[$];
        logic [63:0] exp_busy;
        exp_q = {};
        for (int f = 0; f < frames; f++)
            for (int j = 0; j < J1; j++) exp_q.push_back(j);
        chk("mul_pulses", mul_log.size() - s_mul, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (s_mul + i < mul_log.size()) chk("mul_scale", mul_log[s_mul + i], exp_q[i]);
        chk("store_pulses", base_log.size() - s_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (s_base + i < base_log.size()) chk("store_base", base_log[s_base + i], exp_q[i] * N);
        exp_q = {};
        for (int f = 0; f < frames; f++)
            for (int k = 0; k < TOT; k++) exp_q.push_back(k);
        chk("read_count", addr_log.size() - s_addr, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (s_addr + i < addr_log.size()) chk("rd_addr", addr_log[s_addr + i], exp_q[i]);
        chk("fft_pulses", n_fft - s_fft, frames);
        chk("ifft_pulses", n_ifft - s_ifft, frames * J1);
        chk("valid_count", n_valid - s_valid, frames * TOT);
        chk("last_count", n_last - s_last, frames);
        chk("done_count", n_done - s_done, frames);
        chk("done_with_last", n_dwl - s_dwl, frames);
        chk("rd_en_in_stall", n_bad_rd - s_bad, 0);
        chk("valid_timing", n_verr - s_verr, 0);
        chk("last_timing", n_lerr - s_lerr, 0);
        chk("last_position", n_lpos - s_lpos, 0);
        chk("busy_after_done", n_busy_after - s_after, 0);
        // FFT/MUL/IFFT/STORE each span start cycle + done latency; READ spans
        // TOT issues plus stalls; DONE is one cycle.
        exp_busy = 64'(frames * (1 + 3 * J1 + TOT + 1)) + 64'(lat_sum - s_lat) + 64'(n_stall - s_stall);
        chk("busy_cycles", n_busy - s_busy, exp_busy);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a.start_i   = 1'b0;
        b.start_i   = 1'b0;
        a.dl_busy_i = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outs_a", {a.busy_o, a.cwt_done_o, a.state_o, a.fft_start_o, a.mul_start_o,
                             a.mul_scale_o, a.ifft_start_o, a.store_start_o, a.store_base_o,
                             a.rd_en_o, a.rd_addr_o, a.valid_o, a.last_o}, 0);
        chk("reset_outs_b", {b.busy_o, b.cwt_done_o, b.state_o, b.fft_start_o, b.mul_start_o,
                             b.mul_scale_o, b.ifft_start_o, b.store_start_o, b.store_base_o,
                             b.rd_en_o, b.rd_addr_o, b.valid_o, b.last_o}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // nominal: every done five cycles after its start
        lat_lo = 5; lat_hi = 5; stall_mode = 0; early = 1'b0;
        run_frame_a();
        check_frame_a(1);
        chk("nominal_busy_cycles", n_busy - s_busy, 143);

        // backpressure at addresses 10 and 63
        lat_lo = 1; lat_hi = 6; stall_mode = 1;
        run_frame_a();
        check_frame_a(1);
        chk("stall_cycles", n_stall - s_stall, 6);

        // spurious handshakes, done in start cycle, random stalls
        lat_lo = 3; lat_hi = 6; stall_mode = 2; early = 1'b1;
        snapshot_a();
        @(posedge clk); #1 a.start_i = 1'b1;
        @(posedge clk); #1 a.start_i = 1'b0;
        wait_state_a(1, 0);
        @(posedge clk); #1 xa[1] = 1'b1; a.start_i = 1'b1;
        @(posedge clk); #1 xa[1] = 1'b0; a.start_i = 1'b0;
        @(negedge clk); #1;
        chk("spur_mul_done_in_fft", a.state_o, 1);
        wait_state_a(2, 0);
        @(posedge clk); #1 xa[3] = 1'b1; a.start_i = 1'b1;
        @(posedge clk); #1 xa[3] = 1'b0; a.start_i = 1'b0;
        @(negedge clk); #1;
        chk("spur_store_done_in_mul", a.state_o, 2);
        wait_done_a(s_done + 1);
        early = 1'b0;
        check_frame_a(1);

        // reset during IFFT of scale 2, then a clean frame
        lat_lo = 1; lat_hi = 4; stall_mode = 0;
        @(posedge clk); #1 a.start_i = 1'b1;
        @(posedge clk); #1 a.start_i = 1'b0;
        wait_state_a(3, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("midrst_state", a.state_o, 0);
        chk("midrst_outs", {a.busy_o, a.cwt_done_o, a.fft_start_o, a.mul_start_o, a.mul_scale_o,
                            a.ifft_start_o, a.store_start_o, a.store_base_o, a.rd_en_o,
                            a.rd_addr_o, a.valid_o, a.last_o}, 0);
        @(posedge clk); #1 rst = 1'b0;
        stall_mode = 2;
        run_frame_a();
        check_frame_a(1);

        // back-to-back frames with start held high
        lat_lo = 1; lat_hi = 3; stall_mode = 0;
        snapshot_a();
        @(posedge clk); #1 a.start_i = 1'b1;
        for (int k = 0; k < 4000 && n_fft < s_fft + 2; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 a.start_i = 1'b0;
        wait_done_a(s_done + 2);
        check_frame_a(2);
        chk("b2b_restart_gap", last_gap, 2);

        // single-scale instance
        @(posedge clk); #1 b.start_i = 1'b1;
        @(posedge clk); #1 b.start_i = 1'b0;
        for (int k = 0; k < 500 && nb_done < 1; k++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        chk("b_done_count", nb_done, 1);
        chk("b_fft_pulses", nb_fft, 1);
        chk("b_mul_pulses", nb_mul, 1);
        chk("b_scale_nonzero", nb_scale_err, 0);
        chk("b_store_pulses", nb_store, 1);
        chk("b_store_base", nb_base_err, 0);
        chk("b_reads", nb_rd, NB);
        chk("b_addr_order", nb_addr_err, 0);
        chk("b_valid_count", nb_valid, NB);
        chk("b_last_count", nb_last, 1);
        chk("b_done_with_last", nb_dwl, 1);
        chk("b_busy_cycles", nb_busy, 21);
        chk("b_idle_after", b.busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cwt_sched.md
Name: cwt_sched

Overview:
- Top-level sequencer for the CWT engine.
- Starts the forward FFT once per frame, then loops over J1 scales. Each scale runs multiply by the scale's wavelet filter, IFFT, and a store into that scale's BRAM region.
- Finally streams all N*J1 stored results to the downstream block under dl_busy backpressure.
- Sits between the frame-level start/done handshake and the fft/mul/ifft/store sub-blocks.

Parameters:
- N, 1024: points per transform (power of 2, >=4).
- J1, 4: number of scales (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  frame start request.
- dl_busy_i  in  1  downstream stall; high = do not issue a read.
- busy_o  out  1  high whenever state != IDLE.
- cwt_done_o  out  1  one-cycle pulse at frame completion.
- state_o  out  3  current state encoding.
- fft_start_o  out  1  one-cycle pulse.
- fft_done_i  in  1  FFT complete.
- mul_start_o  out  1  one-cycle pulse.
- mul_scale_o  out  max(1,$clog2(J1))  scale index j, held stable through MUL/IFFT/STORE.
- mul_done_i  in  1  multiply complete.
- ifft_start_o  out  1  one-cycle pulse.
- ifft_done_i  in  1  IFFT complete.
- store_start_o  out  1  one-cycle pulse.
- store_base_o  out  $clog2(N*J1)  BRAM base address, j*N.
- store_done_i  in  1  store complete.
- rd_en_o  out  1  BRAM read enable.
- rd_addr_o  out  $clog2(N*J1)  BRAM read address.
- valid_o  out  1  read data valid, one cycle after rd_en_o.
- last_o  out  1  coincides with the final valid_o.

Behaviour:
- State encoding: IDLE=0, FFT=1, MUL=2, IFFT=3, STORE=4, READ=5, DONE=6.
- Reset: all outputs 0, state IDLE, j=0, rd_addr=0. rst has priority over every input, including mid-operation; pulses in flight are dropped.
- IDLE: start_i=1 at edge k -> state FFT at k+1, fft_start_o=1 during cycle k+1 only.
- FFT: fft_done_i=1 -> MUL; mul_start_o pulses on entry.
- MUL: mul_done_i=1 -> IFFT; ifft_start_o pulses on entry.
- IFFT: ifft_done_i=1 -> STORE; store_start_o pulses on entry; store_base_o = j*N, registered, valid from entry.
- STORE: store_done_i=1 and j<J1-1 -> j=j+1, back to MUL with a new mul_start_o pulse.
- STORE: store_done_i=1 and j=J1-1 -> READ, rd_addr=0.
- Every start pulse is registered: it is high in exactly the first cycle of its state.
- A done input is honoured only while in its own wait state and not in the same cycle as its start pulse. A done in any other state is ignored and has no side effects.
- READ: rd_en_o = !dl_busy_i, combinational from the registered state.
  - Each cycle with rd_en_o=1 increments rd_addr_o.
  - dl_busy_i=1 holds rd_addr_o, rd_en_o=0.
  - valid_o = rd_en_o delayed 1 cycle; last_o = valid_o for address N*J1-1.
  - After issuing address N*J1-1 -> DONE; no wrap, rd_en_o never asserts for address >= N*J1.
- DONE: lasts one cycle, while valid_o/last_o for the final word is asserted. cwt_done_o=1 in that cycle; next state IDLE; j and rd_addr cleared.
- start_i while busy_o=1 is ignored, not queued.
- start_i in the DONE cycle is ignored; start_i in the following IDLE cycle starts a new frame.
- J1=1: STORE goes directly to READ; mul_scale_o is constant 0.
- Frame latency = 1 + t_fft + J1*(t_mul+t_ifft+t_store+3) + N*J1 + stall cycles + 1.

Test Plan:
- Nominal, N=16, J1=4, each done returned 5 cycles after its start:
  - one fft_start_o, then exactly 4 mul/ifft/store pulse triplets with mul_scale_o=0,1,2,3 and store_base_o=0,16,32,48;
  - rd_addr_o 0..63 contiguous, 64 valid_o, last_o on the 64th;
  - cwt_done_o one pulse in the same cycle as that last_o; busy_o low the next cycle.
- Backpressure: dl_busy_i=1 for 3 cycles at rd_addr=10 and again at rd_addr=63:
  - address held and rd_en_o=0 during stalls;
  - no duplicated or skipped addresses; valid_o count = 64.
- Spurious handshakes:
  - mul_done_i pulsed in FFT, store_done_i pulsed in MUL, start_i pulsed while busy: no state change, no extra pulses;
  - done asserted in the start-pulse cycle is ignored; the frame still completes.
- Reset mid-frame: rst=1 during IFFT of j=2 -> next cycle state_o=0 with all outputs 0; a following start_i runs a complete frame from j=0.
- J1=1, N=8: single triplet with store_base_o=0; 8 reads; cwt_done_o pulses once.
- Back-to-back frames: start_i held high continuously -> second frame begins the cycle after IDLE is re-entered; no frame overlaps.
